// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file port.
// Merges pipeline retires with long-latency results via a small FIFO.
module rf_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_stall,
  input  logic        lr_valid,
  output logic        lr_ready,
  input  logic [4:0]  lr_waddr,
  input  logic [31:0] lr_wdata,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        chk_hit1,
  output logic        chk_hit2,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [WW-1:0] WMAX = WW'(STARVE_MAX);

  logic [4:0]       mem_a [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic [CW-1:0]    cnt;
  logic [WW-1:0]    wait_cnt;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic pipe_sel;
  logic hit1;
  logic hit2;

  assign empty      = (cnt == '0);
  assign full       = (cnt == FULL);
  assign lr_ready   = !rst && !full;
  assign push       = lr_valid && lr_ready && (lr_waddr != 5'd0);
  assign pipe_stall = (wait_cnt == WMAX);

  // Pick the write source: forced drain, pipeline, then FIFO head.
  always_comb begin
    pipe_sel = 1'b0;
    pop      = 1'b0;
    if (pipe_stall) begin
      pop = !empty;
    end else if (pipe_valid && (pipe_waddr != 5'd0)) begin
      pipe_sel = 1'b1;
    end else begin
      pop = !empty;
    end
  end

  // FIFO storage; contents are qualified by vld so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wptr] <= lr_waddr;
      mem_d[wptr] <= lr_wdata;
    end
  end

  // FIFO pointers, occupancy and per-slot valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      vld  <= '0;
    end else begin
      if (push) begin
        vld[wptr] <= 1'b1;
        wptr      <= wptr + AW'(1);
      end
      if (pop) begin
        vld[rptr] <= 1'b0;
        rptr      <= rptr + AW'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Count cycles the head waits; saturates to force a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (empty || pop) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WMAX) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // Registered register-file write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else begin
      rf_wen <= pipe_sel || pop;
      if (pipe_sel) begin
        rf_waddr <= pipe_waddr;
        rf_wdata <= pipe_wdata;
      end else if (pop) begin
        rf_waddr <= mem_a[rptr];
        rf_wdata <= mem_d[rptr];
      end
    end
  end

  // Pending-write lookup over FIFO entries and the output stage.
  always_comb begin
    hit1 = rf_wen && (rf_waddr == chk_addr1);
    hit2 = rf_wen && (rf_waddr == chk_addr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (mem_a[i] == chk_addr1)) hit1 = 1'b1;
      if (vld[i] && (mem_a[i] == chk_addr2)) hit2 = 1'b1;
    end
    chk_hit1 = (chk_addr1 != 5'd0) && hit1;
    chk_hit2 = (chk_addr2 != 5'd0) && hit2;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter.
// Scenario tasks with inline hand-computed checks.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        pipe_stall;
  logic        lr_valid;
  logic        lr_ready;
  logic [4:0]  lr_waddr;
  logic [31:0] lr_wdata;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        chk_hit1;
  logic        chk_hit2;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int tests;
  int fails;

  rf_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_waddr(pipe_waddr),
    .pipe_wdata(pipe_wdata), .pipe_stall(pipe_stall),
    .lr_valid(lr_valid), .lr_ready(lr_ready),
    .lr_waddr(lr_waddr), .lr_wdata(lr_wdata),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_valid = 1'b0;
    pipe_waddr = 5'd0;
    pipe_wdata = 32'd0;
    lr_valid   = 1'b0;
    lr_waddr   = 5'd0;
    lr_wdata   = 32'd0;
    chk_addr1  = 5'd0;
    chk_addr2  = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    tests++;
    if (rf_wen !== 1'b0) begin
      fails++; $display("FAIL reset_wen got %b want 0", rf_wen);
    end
    tests++;
    if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_out got %0d/%h want 0/0", rf_waddr, rf_wdata);
    end
    tests++;
    if (lr_ready !== 1'b0 || pipe_stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs got rdy=%b stall=%b want 0/0",
               lr_ready, pipe_stall);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (lr_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release_rdy got %b want 1", lr_ready);
    end
  endtask

  task automatic test_pipe();
    tick();
    tick();
    pipe_valid = 1'b1;
    pipe_waddr = 5'd5;
    pipe_wdata = 32'hDEADBEEF;
    tick();
    pipe_valid = 1'b0;
    tests++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL pipe_write got %b/%0d/%h want 1/5/deadbeef",
               rf_wen, rf_waddr, rf_wdata);
    end
    tick();
    tests++;
    if (rf_wen !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL pipe_hold got %b/%0d/%h want 0/5/deadbeef",
               rf_wen, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_lr();
    pipe_valid = 1'b1; pipe_waddr = 5'd20; pipe_wdata = 32'h20;
    lr_valid   = 1'b1; lr_waddr   = 5'd7;  lr_wdata   = 32'h11;
    tick();
    tests++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd20) begin
      fails++;
      $display("FAIL lr_pipe20 got %b/%0d want 1/20", rf_wen, rf_waddr);
    end
    pipe_waddr = 5'd21; pipe_wdata = 32'h21;
    lr_waddr   = 5'd8;  lr_wdata   = 32'h22;
    #1;
    tests++;
    if (lr_ready !== 1'b1) begin
      fails++; $display("FAIL lr_rdy_one got %b want 1", lr_ready);
    end
    tick();
    pipe_valid = 1'b0;
    lr_waddr   = 5'd9; lr_wdata = 32'h99;
    chk_addr1  = 5'd8; chk_addr2 = 5'd7;
    #1;
    tests++;
    if (lr_ready !== 1'b0) begin
      fails++; $display("FAIL lr_rdy_full got %b want 0", lr_ready);
    end
    tests++;
    if (chk_hit1 !== 1'b1 || chk_hit2 !== 1'b1) begin
      fails++;
      $display("FAIL lr_hit_fifo got %b%b want 11", chk_hit1, chk_hit2);
    end
    tick();
    lr_valid = 1'b0;
    tests++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h11) begin
      fails++;
      $display("FAIL lr_first got %b/%0d/%h want 1/7/11",
               rf_wen, rf_waddr, rf_wdata);
    end
    #1;
    tests++;
    if (chk_hit1 !== 1'b1 || lr_ready !== 1'b1) begin
      fails++;
      $display("FAIL lr_mid got hit=%b rdy=%b want 1/1", chk_hit1, lr_ready);
    end
    tick();
    tests++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h22) begin
      fails++;
      $display("FAIL lr_second got %b/%0d/%h want 1/8/22",
               rf_wen, rf_waddr, rf_wdata);
    end
    tests++;
    if (chk_hit1 !== 1'b1) begin
      fails++; $display("FAIL lr_hit_out got %b want 1", chk_hit1);
    end
    tick();
    tests++;
    if (rf_wen !== 1'b0 || chk_hit1 !== 1'b0) begin
      fails++;
      $display("FAIL lr_done got wen=%b hit=%b want 0/0", rf_wen, chk_hit1);
    end
    chk_addr1 = 5'd0; chk_addr2 = 5'd0;
  endtask

  task automatic test_starve();
    logic [4:0] exp_a [9];
    logic       exp_w [9];
    logic       exp_s [9];
    logic [4:0] k;
    exp_a = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd30, 5'd6, 5'd7};
    exp_w = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    k = 5'd1;
    for (int c = 0; c < 9; c++) begin
      tests++;
      if (pipe_stall !== exp_s[c]) begin
        fails++;
        $display("FAIL starve_stall c%0d got %b want %b",
                 c, pipe_stall, exp_s[c]);
      end
      if (exp_w[c]) begin
        tests++;
        if (rf_wen !== 1'b1 || rf_waddr !== exp_a[c] ||
            rf_wdata !== ((exp_a[c] == 5'd30) ? 32'hAA
                          : 32'h100 + 32'(exp_a[c]))) begin
          fails++;
          $display("FAIL starve_wr c%0d got %b/%0d/%h want 1/%0d",
                   c, rf_wen, rf_waddr, rf_wdata, exp_a[c]);
        end
      end
      pipe_valid = (c < 8);
      pipe_waddr = k;
      pipe_wdata = 32'h100 + 32'(k);
      lr_valid   = (c == 0);
      lr_waddr   = 5'd30;
      lr_wdata   = 32'hAA;
      if (!pipe_stall) k = k + 5'd1;
      tick();
    end
    tests++;
    if (rf_wen !== 1'b0) begin
      fails++; $display("FAIL starve_end got %b want 0", rf_wen);
    end
    idle_inputs();
  endtask

  task automatic test_zero();
    lr_valid = 1'b1; lr_waddr = 5'd0; lr_wdata = 32'h55;
    pipe_valid = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'h66;
    #1;
    tests++;
    if (chk_hit1 !== 1'b0 || chk_hit2 !== 1'b0) begin
      fails++;
      $display("FAIL zero_chk got %b%b want 00", chk_hit1, chk_hit2);
    end
    tick();
    tests++;
    if (rf_wen !== 1'b0) begin
      fails++; $display("FAIL zero_pipe got %b want 0", rf_wen);
    end
    pipe_valid = 1'b0;
    lr_waddr = 5'd12; lr_wdata = 32'h77;
    tick();
    tests++;
    if (rf_wen !== 1'b0) begin
      fails++; $display("FAIL zero_lr got %b want 0", rf_wen);
    end
    lr_valid = 1'b0;
    pipe_valid = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'h88;
    chk_addr1 = 5'd12;
    #1;
    tests++;
    if (chk_hit1 !== 1'b1) begin
      fails++; $display("FAIL zero_hit got %b want 1", chk_hit1);
    end
    tick();
    pipe_valid = 1'b0;
    tests++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h77) begin
      fails++;
      $display("FAIL zero_bubble_pop got %b/%0d/%h want 1/12/77",
               rf_wen, rf_waddr, rf_wdata);
    end
    tick();
    tests++;
    if (rf_wen !== 1'b0) begin
      fails++; $display("FAIL zero_idle got %b want 0", rf_wen);
    end
    chk_addr1 = 5'd0;
  endtask

  task automatic test_reset_mid();
    pipe_valid = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h3;
    lr_valid = 1'b1; lr_waddr = 5'd14; lr_wdata = 32'hE;
    tick();
    pipe_waddr = 5'd4; pipe_wdata = 32'h4;
    lr_waddr = 5'd15; lr_wdata = 32'hF;
    tick();
    idle_inputs();
    chk_addr1 = 5'd14;
    #1;
    tests++;
    if (lr_ready !== 1'b0 || rf_wen !== 1'b1 || rf_waddr !== 5'd4) begin
      fails++;
      $display("FAIL rstmid_full got rdy=%b wen=%b a=%0d want 0/1/4",
               lr_ready, rf_wen, rf_waddr);
    end
    rst = 1'b1;
    tick();
    tests++;
    if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || lr_ready !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_cyc got wen=%b a=%0d rdy=%b want 0/0/0",
               rf_wen, rf_waddr, lr_ready);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (lr_ready !== 1'b1 || chk_hit1 !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_rel got rdy=%b hit=%b want 1/0",
               lr_ready, chk_hit1);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if (rf_wen !== 1'b0 || pipe_stall !== 1'b0) begin
        fails++;
        $display("FAIL rstmid_stale c%0d got wen=%b stall=%b want 0/0",
                 c, rf_wen, pipe_stall);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_pipe();
    test_lr();
    test_starve();
    test_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
